// File: rtl/io_ccff_loader.sv
// Serial configuration loader for the io tile ccff chain: shifts a word-fed
// bitstream into the chain, recirculates it once, and compares CRC-8 of both passes.
module io_ccff_loader #(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CW-1:0] LEN      = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SHIFT  = 3'd2,
    S_RECIRC = 3'd3,
    S_CHECK  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WORD_W-1:0] r_shift;
  logic [CW-1:0]     r_remaining;
  logic [BW-1:0]     r_bitcnt;
  logic [7:0]        r_crc_load;
  logic [7:0]        r_crc_read;
  logic              r_head_last;
  logic              r_done;
  logic              r_err;
  logic              w_last_bit;
  logic              w_word_end;
  logic              w_kill;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // r_remaining counts chain bits left in SHIFT, then recirculation cycles left in RECIRC
  assign w_last_bit = (r_remaining == ONE);
  assign w_word_end = w_last_bit || (r_bitcnt == LAST_BIT);
  assign w_kill     = abort && (r_state != S_IDLE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start && !abort) w_state_next = S_FETCH;
      S_FETCH:  if (cfg_valid) w_state_next = S_SHIFT;
      S_SHIFT:  if (w_word_end) w_state_next = w_last_bit ? S_RECIRC : S_FETCH;
      S_RECIRC: if (w_last_bit) w_state_next = S_CHECK;
      S_CHECK:  w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    if (w_kill) w_state_next = S_IDLE;
  end

  // Abort gates the strobes in its own cycle so neither the chain nor the source moves
  always_comb begin
    cfg_ready     = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    case (r_state)
      S_FETCH: begin
        cfg_ready = !abort;
        ccff_head = r_head_last;
      end
      S_SHIFT: begin
        ccff_shift_en = !abort;
        ccff_head     = r_shift[0];
      end
      S_RECIRC: begin
        ccff_shift_en = !abort;
        ccff_head     = ccff_tail;
      end
      S_CHECK:  ccff_head = r_head_last;
      default:  ccff_head = 1'b0;
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign err  = r_err;

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_remaining <= '0;
      r_bitcnt    <= '0;
      r_crc_load  <= '0;
      r_crc_read  <= '0;
      r_head_last <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_head_last <= ccff_head;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_remaining <= LEN;
            r_bitcnt    <= '0;
            r_crc_load  <= '0;
            r_crc_read  <= '0;
            r_err       <= 1'b0;
          end
        end
        S_FETCH: begin
          if (cfg_valid) begin
            r_shift  <= cfg_data;
            r_bitcnt <= '0;
          end
        end
        S_SHIFT: begin
          r_shift    <= r_shift >> 1;
          r_bitcnt   <= r_bitcnt + 1'b1;
          r_crc_load <= crc8_step(r_crc_load, r_shift[0]);
          r_remaining <= (w_word_end && w_last_bit) ? LEN : (r_remaining - ONE);
        end
        S_RECIRC: begin
          r_remaining <= r_remaining - ONE;
          r_crc_read  <= crc8_step(r_crc_read, ccff_tail);
        end
        S_CHECK: begin
          r_done <= 1'b1;
          r_err  <= (r_crc_load != r_crc_read);
        end
        default: ;
      endcase
      if (w_kill) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_ccff_loader.sv
// Randomized bench for io_ccff_loader: a bit-level chain model, expected head
// streams derived from the words (LSB first, truncated to the chain length).
`timescale 1ns/1ps
module tb_io_ccff_loader;

  localparam int CL = 20;
  localparam int WW = 8;
  localparam int NW = (CL + WW - 1) / WW;

  logic          prog_clk = 1'b0;
  logic          pReset;
  logic          start;
  logic          abort;
  logic [WW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic          err;

  logic [CL-1:0] chain;
  logic [CL-1:0] keep_mask;

  int n_vec = 0;
  int n_bad = 0;

  always #5 prog_clk = ~prog_clk;

  io_ccff_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) u_dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .abort         (abort),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  // Chain: bit enters at [0], leaves at [CL-1]; keep_mask models a stuck-at-0 cell
  assign ccff_tail = chain[CL-1];
  always @(posedge prog_clk) begin
    if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head} & keep_mask;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_sh"},   32'(ccff_shift_en), 0);
    chk({tag, "_rdy"},  32'(cfg_ready), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_head"}, 32'(ccff_head), 0);
    chk({tag, "_err"},  32'(err), 0);
  endtask

  // One load request; abort_after>0 aborts after that many load pulses,
  // rst_at>0 pulses reset after that many recirculation pulses.
  task automatic run_load(input bit use_stuck, input bit force_stall,
                          input int abort_after, input int rst_at);
    logic [WW-1:0] words [NW];
    logic [CL-1:0] exp_img;
    bit            exp_bits [CL];
    int            widx, load_cnt, recirc_cnt, stall_left, last_rc_cyc;
    logic          last_head;
    bit            finished, xfer_prev;

    for (int i = 0; i < NW; i++) words[i] = use_stuck ? '1 : WW'($urandom);
    for (int k = 0; k < CL; k++) begin
      exp_bits[k]       = words[k / WW][k % WW];
      exp_img[CL-1-k]   = exp_bits[k];
    end
    keep_mask = '1;
    if (use_stuck) keep_mask[5] = 1'b0;
    widx = 0; load_cnt = 0; recirc_cnt = 0; last_rc_cyc = 0;
    stall_left = force_stall ? 5 : 0;
    last_head = 1'b0; finished = 0; xfer_prev = 0;

    @(negedge prog_clk);
    start = 1'b1; abort = 1'b0; cfg_valid = 1'b0;
    @(negedge prog_clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (cyc > 0) @(negedge prog_clk);
      cfg_valid = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      cfg_data  = (widx < NW) ? words[widx] : WW'($urandom);
      abort     = (abort_after > 0) && (load_cnt == abort_after);
      pReset    = !((rst_at > 0) && (recirc_cnt == rst_at));
      #1;
      if (cyc == 0) begin
        chk("err_clr",   32'(err), 0);
        chk("fetch_lat", 32'(cfg_ready), 1);
      end
      if (abort || !pReset) begin
        @(negedge prog_clk);
        abort = 1'b0; pReset = 1'b1; cfg_valid = 1'b0;
        #1;
        check_idle_outputs("kill");
        for (int j = 0; j < 3; j++) begin
          @(negedge prog_clk); #1;
          chk("kill_nodone", 32'(done), 0);
          chk("kill_idle",   32'(busy), 0);
        end
        finished = 1;
      end else begin
        if (xfer_prev) chk("sh_after_x", 32'(ccff_shift_en), 1);
        xfer_prev = 0;
        if (cfg_ready) begin
          chk("fetch_sh", 32'(ccff_shift_en), 0);
          chk("fetch_hd", 32'(ccff_head), 32'(last_head));
          if (cfg_valid) begin
            chk("xfer_ok", 32'(widx < NW), 1);
            widx++;
            xfer_prev = 1;
          end
          if (stall_left > 0) stall_left--;
        end
        if (ccff_shift_en) begin
          if (load_cnt < CL) begin
            chk("head_bit", 32'(ccff_head), 32'(exp_bits[load_cnt]));
            load_cnt++;
          end else if (recirc_cnt < CL) begin
            chk("recirc_hd", 32'(ccff_head), 32'(ccff_tail));
            recirc_cnt++;
            last_rc_cyc = cyc;
          end else begin
            chk("extra_sh", 32'(ccff_shift_en), 0);
          end
        end
        if (done) begin
          finished = 1;
          chk("load_pulses",  32'(load_cnt), CL);
          chk("recirc_pulses", 32'(recirc_cnt), CL);
          chk("words_used",   32'(widx), NW);
          chk("done_lat",     32'(cyc - last_rc_cyc), 2);
          chk("err_end",      32'(err), 32'(use_stuck));
          chk("done_busy",    32'(busy), 0);
          if (!use_stuck) chk("chain", 32'(chain), 32'(exp_img));
          @(negedge prog_clk); #1;
          chk("done_1cyc", 32'(done), 0);
          chk("err_hold",  32'(err), 32'(use_stuck));
        end
        last_head = ccff_head;
      end
    end
    if (!finished) chk("timeout", 32'(done), 1);
  endtask

  initial begin
    pReset = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_valid = 1'b0; cfg_data = '0;
    keep_mask = '1; chain = '0;

    repeat (3) @(negedge prog_clk);
    start = 1'b1; cfg_valid = 1'b1;
    @(negedge prog_clk); #1;
    check_idle_outputs("rst");
    pReset = 1'b1; start = 1'b0; cfg_valid = 1'b0;

    repeat (3) run_load(1'b0, 1'b0, 0, 0);
    run_load(1'b0, 1'b1, 0, 0);
    run_load(1'b1, 1'b0, 0, 0);
    run_load(1'b0, 1'b0, 0, 0);
    run_load(1'b0, 1'b0, 2, 0);

    // start together with abort in IDLE is refused
    @(negedge prog_clk);
    start = 1'b1; abort = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; abort = 1'b0;
    #1;
    chk("sa_busy", 32'(busy), 0);
    chk("sa_rdy",  32'(cfg_ready), 0);
    @(negedge prog_clk); #1;
    chk("sa_busy2", 32'(busy), 0);

    run_load(1'b0, 1'b0, 0, 5);
    run_load(1'b0, 1'b1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
